// File: rtl/backprop_sequencer.sv
// Backward-pass scheduler: walks a cost pass, then every weight layer from last to first, row by row.
// Optional `step_count` output is compiled in with `define BACKPROP_SEQ_STEP_COUNT_EN.
module backprop_sequencer #(
    parameter int size        = 3,
    parameter int layer_count = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode_cost,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic        is_update,
    output logic        is_cost_layer,
    output logic        backprop_cost,
    output logic [31:0] w_layer_index,
    output logic [31:0] w_row_index
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
    ,
    output logic [31:0] step_count
`endif
);

    localparam int ROW_W   = (size > 1) ? $clog2(size) : 1;
    localparam int LAYER_W = (layer_count > 1) ? $clog2(layer_count) : 1;
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(size - 1);
    localparam logic [LAYER_W-1:0] LAYER_TOP = LAYER_W'(layer_count - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_COST, ST_LAYER, ST_DONE} state_t;

    // r_state/r_row/r_layer hold the step to be issued next (the cursor);
    // the r_o_* registers present the step issued on the previous edge.
    state_t               r_state;
    logic [ROW_W-1:0]     r_row;
    logic [LAYER_W-1:0]   r_layer;
    logic                 r_mode;
    logic                 r_o_busy, r_o_done, r_o_upd, r_o_cl, r_o_bpc;
    logic [LAYER_W-1:0]   r_o_layer;
    logic [ROW_W-1:0]     r_o_row;

    state_t               w_next_state, w_step_state;
    logic [ROW_W-1:0]     w_next_row, w_step_row;
    logic [LAYER_W-1:0]   w_next_layer, w_step_layer;
    logic                 w_next_mode, w_step_mode;
    logic                 w_active, w_issue, w_start_acc;
    logic                 w_o_busy, w_o_done, w_o_upd, w_o_cl, w_o_bpc;
    logic [LAYER_W-1:0]   w_o_layer;
    logic [ROW_W-1:0]     w_o_row;

    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_layer = r_layer;
        w_next_mode  = r_mode;
        w_step_state = r_state;
        w_step_row   = r_row;
        w_step_layer = r_layer;
        w_step_mode  = r_mode;
        w_active     = 1'b0;
        w_issue      = 1'b0;
        w_start_acc  = 1'b0;
        w_o_busy     = 1'b0;
        w_o_done     = 1'b0;
        w_o_upd      = 1'b0;
        w_o_cl       = 1'b0;
        w_o_bpc      = 1'b0;
        w_o_layer    = '0;
        w_o_row      = '0;

        case (r_state)
            ST_IDLE: begin
                // r_o_busy still high means the DONE pulse is on the outputs this cycle.
                if (start && !r_o_busy) begin
                    w_start_acc  = 1'b1;
                    w_next_mode  = mode_cost;
                    w_step_state = ST_COST;
                    w_step_row   = '0;
                    w_step_layer = LAYER_TOP;
                    w_step_mode  = mode_cost;
                    w_active     = 1'b1;
                    w_issue      = 1'b1;
                end
            end
            ST_COST, ST_LAYER: begin
                w_active = 1'b1;
                w_issue  = !hold;
            end
            ST_DONE: begin
                w_o_busy     = 1'b1;
                w_o_done     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (w_active) begin
            w_o_busy  = 1'b1;
            w_o_upd   = w_issue;
            w_o_cl    = (w_step_state == ST_COST);
            w_o_bpc   = (w_step_state == ST_COST) ? 1'b1 : w_step_mode;
            w_o_layer = w_step_layer;
            w_o_row   = w_step_row;
            if (w_issue) begin
                w_next_state = w_step_state;
                w_next_layer = w_step_layer;
                if (w_step_row == ROW_LAST) begin
                    w_next_row = '0;
                    if (w_step_state == ST_COST) begin
                        w_next_state = ST_LAYER;
                        w_next_layer = LAYER_TOP;
                    end else if (w_step_layer == '0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_layer = w_step_layer - LAYER_W'(1);
                    end
                end else begin
                    w_next_row = w_step_row + ROW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_layer   <= '0;
            r_mode    <= 1'b0;
            r_o_busy  <= 1'b0;
            r_o_done  <= 1'b0;
            r_o_upd   <= 1'b0;
            r_o_cl    <= 1'b0;
            r_o_bpc   <= 1'b0;
            r_o_layer <= '0;
            r_o_row   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_row     <= w_next_row;
            r_layer   <= w_next_layer;
            r_mode    <= w_next_mode;
            r_o_busy  <= w_o_busy;
            r_o_done  <= w_o_done;
            r_o_upd   <= w_o_upd;
            r_o_cl    <= w_o_cl;
            r_o_bpc   <= w_o_bpc;
            r_o_layer <= w_o_layer;
            r_o_row   <= w_o_row;
        end
    end

`ifdef BACKPROP_SEQ_STEP_COUNT_EN
    logic [31:0] r_step_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_count <= '0;
        end else if (w_start_acc) begin
            r_step_count <= '0;
        end else if (r_o_upd) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign step_count = r_step_count;
`endif

    assign busy          = r_o_busy;
    assign done          = r_o_done;
    assign is_update     = r_o_upd;
    assign is_cost_layer = r_o_cl;
    assign backprop_cost = r_o_bpc;
    assign w_layer_index = 32'(r_o_layer);
    assign w_row_index   = 32'(r_o_row);

endmodule

// File: tb/tb_backprop_sequencer.sv
// Scoreboard bench for backprop_sequencer: a 3-row/2-layer instance and a 1-row/1-layer instance.
module tb_backprop_sequencer;

    typedef struct {
        int cyc;
        int layer;
        int row;
        int cl;
        int bpc;
        int dn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic        a_reset, a_start, a_mode, a_hold;
    logic        a_busy, a_done, a_upd, a_cl, a_bpc;
    logic [31:0] a_layer, a_row;
    logic        b_reset, b_start, b_mode, b_hold;
    logic        b_busy, b_done, b_upd, b_cl, b_bpc;
    logic [31:0] b_layer, b_row;
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
    logic [31:0] a_sc, b_sc;
`endif

    backprop_sequencer #(.size(3), .layer_count(2)) dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .mode_cost(a_mode), .hold(a_hold),
        .busy(a_busy), .done(a_done), .is_update(a_upd), .is_cost_layer(a_cl),
        .backprop_cost(a_bpc), .w_layer_index(a_layer), .w_row_index(a_row)
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
        , .step_count(a_sc)
`endif
    );

    backprop_sequencer #(.size(1), .layer_count(1)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .mode_cost(b_mode), .hold(b_hold),
        .busy(b_busy), .done(b_done), .is_update(b_upd), .is_cost_layer(b_cl),
        .backprop_cost(b_bpc), .w_layer_index(b_layer), .w_row_index(b_row)
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
        , .step_count(b_sc)
`endif
    );

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_a(input int c, input int layer, input int row, input int cl, input int bpc, input int dn);
        exp_t e;
        e.cyc = c; e.layer = layer; e.row = row; e.cl = cl; e.bpc = bpc; e.dn = dn;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int layer, input int row, input int cl, input int bpc, input int dn);
        exp_t e;
        e.cyc = c; e.layer = layer; e.row = row; e.cl = cl; e.bpc = bpc; e.dn = dn;
        qb.push_back(e);
    endtask

    // 3-row/2-layer pass started in cycle c: COST (1,0..2), LAYER (1,0..2), (0,0..2), then done.
    // Steps from hold_step onward slip by hold_len cycles; nsteps < 9 means the pass is cut short.
    task automatic exp_pass_a(input int c, input int mode, input int hold_step, input int hold_len, input int nsteps);
        int t;
        for (int j = 0; j < nsteps; j++) begin
            t = c + 1 + j + ((j >= hold_step) ? hold_len : 0);
            if (j < 3) push_a(t, 1, j, 1, 1, 0);
            else       push_a(t, 1 - (j - 3) / 3, (j - 3) % 3, 0, mode, 0);
        end
        if (nsteps == 9) push_a(c + 10 + ((hold_step < 9) ? hold_len : 0), 0, 0, 0, 0, 1);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"},  int'(a_busy), 0);
        check({tag, "_done"},  int'(a_done), 0);
        check({tag, "_upd"},   int'(a_upd), 0);
        check({tag, "_cl"},    int'(a_cl), 0);
        check({tag, "_bpc"},   int'(a_bpc), 0);
        check({tag, "_layer"}, int'(a_layer), 0);
        check({tag, "_row"},   int'(a_row), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_upd || a_done) begin
            $display("A cyc=%0d layer=%0d row=%0d cl=%0b bpc=%0b done=%0b", cyc, a_layer, a_row, a_cl, a_bpc, a_done);
            if (qa.size() == 0) begin
                check("a_unexpected_output", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_cycle", cyc, e.cyc);
                check("a_layer", int'(a_layer), e.layer);
                check("a_row",   int'(a_row), e.row);
                check("a_cost_layer", int'(a_cl), e.cl);
                check("a_backprop_cost", int'(a_bpc), e.bpc);
                check("a_done",  int'(a_done), e.dn);
                check("a_busy",  int'(a_busy), 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_upd || b_done) begin
            $display("B cyc=%0d layer=%0d row=%0d cl=%0b bpc=%0b done=%0b", cyc, b_layer, b_row, b_cl, b_bpc, b_done);
            if (qb.size() == 0) begin
                check("b_unexpected_output", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_cycle", cyc, e.cyc);
                check("b_layer", int'(b_layer), e.layer);
                check("b_row",   int'(b_row), e.row);
                check("b_cost_layer", int'(b_cl), e.cl);
                check("b_backprop_cost", int'(b_bpc), e.bpc);
                check("b_done",  int'(b_done), e.dn);
            end
        end
    end

    initial begin
        int c;
        a_reset = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_hold = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_hold = 1'b0;
        repeat (3) tick();
        a_reset = 1'b0; b_reset = 1'b0;
        tick();
        check_idle_a("reset");
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
        check("reset_step_count", int'(a_sc), 0);
`endif

        // plain pass, mode_cost=1
        c = cyc; a_mode = 1'b1; a_start = 1'b1;
        exp_pass_a(c, 1, 99, 0, 9);
        tick(); a_start = 1'b0;
        repeat (9) tick();
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
        check("step_count_at_done", int'(a_sc), 9);
`endif
        repeat (3) tick();

        // plain pass, mode_cost=0
        c = cyc; a_mode = 1'b0; a_start = 1'b1;
        exp_pass_a(c, 0, 99, 0, 9);
        tick(); a_start = 1'b0;
        repeat (12) tick();

        // two held cycles on LAYER (1,1)
        c = cyc; a_mode = 1'b1; a_start = 1'b1;
        exp_pass_a(c, 1, 4, 2, 9);
        tick(); a_start = 1'b0;
        repeat (3) tick();
        a_hold = 1'b1;
        tick();
        check("hold1_upd", int'(a_upd), 0);
        check("hold1_layer", int'(a_layer), 1);
        check("hold1_row", int'(a_row), 1);
        check("hold1_busy", int'(a_busy), 1);
        check("hold1_cl", int'(a_cl), 0);
        tick();
        check("hold2_upd", int'(a_upd), 0);
        check("hold2_row", int'(a_row), 1);
        a_hold = 1'b0;
        repeat (10) tick();

        // start pulsed again while COST (1,1) is on the outputs
        c = cyc; a_start = 1'b1;
        exp_pass_a(c, 1, 99, 0, 9);
        tick(); a_start = 1'b0;
        tick(); a_start = 1'b1;
        tick(); a_start = 1'b0;
        repeat (11) tick();

        // reset while LAYER (0,0) is on the outputs
        c = cyc; a_start = 1'b1;
        exp_pass_a(c, 1, 99, 0, 7);
        tick(); a_start = 1'b0;
        repeat (6) tick();
        a_reset = 1'b1;
        tick();
        check_idle_a("midreset");
        a_reset = 1'b0;
        repeat (4) tick();

        // reset and start together: reset wins
        a_reset = 1'b1; a_start = 1'b1;
        tick();
        check("rst_start_busy", int'(a_busy), 0);
        check("rst_start_upd", int'(a_upd), 0);
        a_reset = 1'b0; a_start = 1'b0;
        tick();
        check("rst_start_busy2", int'(a_busy), 0);

        // restart after reset, start held through the DONE cycle and the following IDLE cycle
        c = cyc; a_start = 1'b1;
        exp_pass_a(c, 1, 99, 0, 9);
        tick(); a_start = 1'b0;
        repeat (9) tick();
        check("done_visible", int'(a_done), 1);
        a_start = 1'b1;
        tick();
        exp_pass_a(cyc, 1, 99, 0, 9);
        tick(); a_start = 1'b0;
        repeat (12) tick();

        // size=1, layer_count=1 instance
        c = cyc; b_mode = 1'b0; b_start = 1'b1;
        push_b(c + 1, 0, 0, 1, 1, 0);
        push_b(c + 2, 0, 0, 0, 0, 0);
        push_b(c + 3, 0, 0, 0, 0, 1);
        tick(); b_start = 1'b0;
        repeat (4) tick();
`ifdef BACKPROP_SEQ_STEP_COUNT_EN
        check("b_step_count", int'(b_sc), 2);
`endif
        check("b_idle_busy", int'(b_busy), 0);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
